uart_program_loader: RTL and testbench

Receives a framed program image as a byte stream from the UART receive path and writes it word-by-word into instruction/data RAM before the core runs. Sits upstream of the ram block and the pc. While loading it holds the CPU via cpu_hold so the pc and register file stay in reset. On success it releases the core; on a bad frame it latches an error and keeps the core held.

---
 rtl/uart_program_loader.sv | 194 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Receives a framed program image over the UART byte stream and writes it word-by-word into RAM,
// holding the core in reset until a frame with a good checksum has been fully committed.
module uart_program_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        arm,
   input  logic        mem_ready,
   output logic        mem_write_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [1:0]  error_code,
   output logic [15:0] words_written
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle, StLenLo, StLenHi, StData, StWrite, StCheck, StDone, StError
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [15:0]   word_idx_q, word_idx_d;
   logic [15:0]   words_q, words_d;
   logic [31:0]   word_q, word_d;
   logic [7:0]    csum_q, csum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          hold_q, hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic [15:0]   n_words;
   logic          timed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         len_q      <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         words_q    <= '0;
         word_q     <= '0;
         csum_q     <= '0;
         tmo_q      <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         words_q    <= words_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      words_d    = words_q;
      word_d     = word_q;
      csum_d     = csum_q;
      tmo_d      = '0;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;
      code_d     = code_q;
      n_words    = {rx_data, len_q[7:0]};
      timed      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (arm && rx_valid && rx_data == 8'hA5) begin
               state_d    = StLenLo;
               hold_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               code_d     = 2'd0;
               words_d    = '0;
               word_idx_d = '0;
               byte_idx_d = '0;
               csum_d     = '0;
            end
         end
         StLenLo: begin
            timed = 1'b1;
            if (rx_valid) begin
               len_d[7:0] = rx_data;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            timed = 1'b1;
            if (rx_valid) begin
               len_d[15:8] = rx_data;
               if (32'(n_words) > MAX_WORDS) begin
                  state_d = StError;
                  err_d   = 1'b1;
                  code_d  = 2'd2;
               end else if (n_words == 16'd0) begin
                  state_d = StCheck;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            timed = 1'b1;
            if (rx_valid) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               csum_d     = csum_q ^ rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = StWrite;
            end
         end
         StWrite: begin
            if (mem_ready) begin
               words_d    = words_q + 16'd1;
               word_idx_d = word_idx_q + 16'd1;
               state_d    = (word_idx_q + 16'd1 == len_q) ? StCheck : StData;
            end
            // A byte arriving while the word is still pending has nowhere to go.
            if (rx_valid) begin
               state_d = StError;
               err_d   = 1'b1;
               code_d  = 2'd3;
            end
         end
         StCheck: begin
            timed = 1'b1;
            if (rx_valid) begin
               if (rx_data == csum_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StError;
                  err_d   = 1'b1;
                  code_d  = 2'd1;
               end
            end
         end
         StDone: begin
            done_d = 1'b1;
            hold_d = 1'b0;
            if (!arm) state_d = StIdle;
         end
         StError: begin
            err_d  = 1'b1;
            hold_d = 1'b1;
            if (!arm) state_d = StIdle;
         end
      endcase

      // Counter restarts on every byte and on every state change.
      if (timed && !rx_valid && state_d == state_q) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = 2'd3;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   assign mem_write_en  = (state_q == StWrite);
   assign mem_addr      = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
   assign mem_wdata     = word_q;
   assign cpu_hold      = hold_q;
   assign load_done     = done_q;
   assign load_error    = err_q;
   assign error_code    = code_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected RAM writes are queued as bytes are driven
// and checked by a monitor whenever the loader commits a word.
module tb_uart_program_loader;

   localparam int unsigned TMO = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        arm = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [1:0]  error_code;
   logic [15:0] words_written;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];

   uart_program_loader #(
      .BASE_ADDR(32'h0000_0000),
      .MAX_WORDS(1024),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .arm(arm),
      .mem_ready(mem_ready),
      .mem_write_en(mem_write_en),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold),
      .load_done(load_done),
      .load_error(load_error),
      .error_code(error_code),
      .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_write_en === 1'b1 && mem_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                     mem_addr, mem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               bad++;
               $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_write();
      int n = 0;
      while (mem_write_en === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (mem_write_en !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL wait_write: got write still pending after %0d cycles, required done", n);
      end
   endtask

   task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
      exp_q.push_back({addr, w});
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
      wait_write();
   endtask

   function automatic logic [7:0] xor4(input logic [31:0] w);
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

   task automatic rearm();
      arm = 1'b0;
      tick();
      arm = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if ({cpu_hold, load_done, load_error, error_code} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_flags: got hold=%b done=%b err=%b code=%0d, required 1 0 0 0",
                  cpu_hold, load_done, load_error, error_code);
      end
      total++;
      if (words_written !== 16'd0 || mem_write_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_mem: got ww=%0d we=%b, required 0 0", words_written, mem_write_en);
      end
   endtask

   task automatic test_single();
      arm = 1'b1;
      mem_ready = 1'b1;
      tick();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_word(32'h0, 32'h1234_5678);
      send_byte(8'h08);
      tick();
      tick();
      total++;
      if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
         bad++;
         $display("FAIL single_done: got done=%b hold=%b, required 1 0", load_done, cpu_hold);
      end
      total++;
      if (words_written !== 16'd1 || load_error !== 1'b0) begin
         bad++;
         $display("FAIL single_count: got ww=%0d err=%b, required 1 0", words_written, load_error);
      end
      arm = 1'b0;
      tick();
      tick();
      total++;
      if (load_done !== 1'b1) begin
         bad++;
         $display("FAIL done_sticky: got %b, required 1", load_done);
      end
   endtask

   task automatic test_stall();
      logic [31:0] w0 = 32'hDEAD_BEEF;
      logic [31:0] w1 = 32'h0BAD_F00D;
      arm = 1'b1;
      tick();
      send_byte(8'hA5);
      total++;
      if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
         bad++;
         $display("FAIL sync_rehold: got hold=%b done=%b, required 1 0", cpu_hold, load_done);
      end
      send_byte(8'h02);
      send_byte(8'h00);
      mem_ready = 1'b0;
      exp_q.push_back({32'h0, w0});
      for (int i = 0; i < 4; i++) send_byte(w0[8*i +: 8]);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (mem_write_en !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== w0) begin
            bad++;
            $display("FAIL stall_hold%0d: got we=%b addr=%h data=%h, required 1 0 %h",
                     k, mem_write_en, mem_addr, mem_wdata, w0);
         end
         tick();
      end
      mem_ready = 1'b1;
      wait_write();
      send_word(32'h4, w1);
      send_byte(xor4(w0) ^ xor4(w1));
      tick();
      tick();
      total++;
      if (load_done !== 1'b1 || words_written !== 16'd2 || cpu_hold !== 1'b0) begin
         bad++;
         $display("FAIL stall_done: got done=%b ww=%0d hold=%b, required 1 2 0",
                  load_done, words_written, cpu_hold);
      end
   endtask

   task automatic test_bad_checksum();
      rearm();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_word(32'h0, 32'h1234_5678);
      send_byte(8'h00);
      tick();
      total++;
      if ({load_error, error_code, cpu_hold, load_done} !== 5'b1_01_1_0) begin
         bad++;
         $display("FAIL checksum: got err=%b code=%0d hold=%b done=%b, required 1 1 1 0",
                  load_error, error_code, cpu_hold, load_done);
      end
   endtask

   task automatic test_length();
      rearm();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h04);
      tick();
      total++;
      if (load_error !== 1'b1 || error_code !== 2'd2 || words_written !== 16'd0) begin
         bad++;
         $display("FAIL len_max: got err=%b code=%0d ww=%0d, required 1 2 0",
                  load_error, error_code, words_written);
      end
      rearm();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      tick();
      tick();
      total++;
      if ({load_done, load_error, error_code, cpu_hold} !== 5'b1_0_00_0 ||
          words_written !== 16'd0) begin
         bad++;
         $display("FAIL len_zero: got done=%b err=%b code=%0d hold=%b ww=%0d, required 1 0 0 0 0",
                  load_done, load_error, error_code, cpu_hold, words_written);
      end
   endtask

   task automatic test_timeout();
      rearm();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h78);
      send_byte(8'h56);
      repeat (TMO - 1) tick();
      total++;
      if (load_error !== 1'b0) begin
         bad++;
         $display("FAIL timeout_early: got err=%b, required 0", load_error);
      end
      tick();
      total++;
      if (load_error !== 1'b1 || error_code !== 2'd3) begin
         bad++;
         $display("FAIL timeout: got err=%b code=%0d, required 1 3", load_error, error_code);
      end
   endtask

   task automatic test_overrun();
      rearm();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1));
      total++;
      if (mem_write_en !== 1'b1) begin
         bad++;
         $display("FAIL overrun_pending: got we=%b, required 1", mem_write_en);
      end
      send_byte(8'h99);
      mem_ready = 1'b1;
      tick();
      total++;
      if (load_error !== 1'b1 || error_code !== 2'd3 || mem_write_en !== 1'b0) begin
         bad++;
         $display("FAIL overrun: got err=%b code=%0d we=%b, required 1 3 0",
                  load_error, error_code, mem_write_en);
      end
   endtask

   task automatic test_reset_mid();
      logic saw_we = 1'b0;
      rearm();
      send_byte(8'hA5);
      send_byte(8'h05);
      send_byte(8'h00);
      for (int i = 0; i < 3; i++) send_word(32'(4 * i), 32'hA000_0000 + 32'(i));
      total++;
      if (words_written !== 16'd3) begin
         bad++;
         $display("FAIL mid_count: got ww=%0d, required 3", words_written);
      end
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({cpu_hold, load_done, load_error, error_code, mem_write_en} !== 6'b1_0_0_00_0 ||
          words_written !== 16'd0) begin
         bad++;
         $display("FAIL mid_reset: got hold=%b done=%b err=%b code=%0d we=%b ww=%0d",
                  cpu_hold, load_done, load_error, error_code, mem_write_en, words_written);
      end
      arm = 1'b0;
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 6; i++) begin
         send_byte(8'(i));
         if (mem_write_en !== 1'b0) saw_we = 1'b1;
      end
      total++;
      if (saw_we !== 1'b0 || words_written !== 16'd0 || cpu_hold !== 1'b1) begin
         bad++;
         $display("FAIL unarmed: got we_seen=%b ww=%0d hold=%b, required 0 0 1",
                  saw_we, words_written, cpu_hold);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_bad_checksum();
      test_length();
      test_timeout();
      test_overrun();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
